serialiser: RTL
===============

Name: serialiser

Overview:
- Transmit-side counterpart of the on-chip/FPGA deserialiser: converts parallel words into a serial bitstream plus a generated slow serial clock, all driven from one fast clock.
- Slow clock is a programmable divide of `clock`. Data launch is placed a programmable number of fast-clock cycles after each slow-clock rising edge, so the receiver's sampling point can be margined.
- Used for chip configuration and test-pattern injection.

Parameters:
- DATA_WIDTH, 32, bits per word, shifted MSB first.
- HP_WIDTH, 4, width of the half-period and delay controls.

Ports:
- clock  in  1  fast clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- half_period  in  HP_WIDTH  slow-clock half period minus 1; period P = 2*(half_period+1) fast cycles.
- delay  in  HP_WIDTH  fast cycles after the slow-clock rising edge at which ser_data_out updates.
- word_in  in  DATA_WIDTH  word to transmit.
- word_valid  in  1  word_in valid.
- word_ready  out  1  block can accept a word.
- ser_clock_out  out  1  generated slow clock.
- ser_data_out  out  1  serial data.
- busy  out  1  a word is shifting or buffered.
- underrun  out  1  sticky: a word ended with no follow-on word while word_valid was high but not yet accepted; cleared by reset only.

Behaviour:
- Reset values while reset=0: phase=0, hp_s=all-ones, dly_s=0, ser_clock_out=0, ser_data_out=0, word_ready=0, busy=0, underrun=0, state=IDLE, buffer empty.
  - word_ready rises on the first clock edge after reset deasserts.
  - Reset mid-word aborts the word immediately (async). The buffered word is discarded.
- Phase counter:
  - Update rule: phase <= (phase==2*hp_s+1) ? 0 : phase+1.
  - Shadow load: on the edge where phase wraps to 0, hp_s<=half_period and dly_s<=min(delay, 2*half_period+1). Changes to half_period/delay therefore take effect only at a period boundary, never mid-period.
- Slow clock: ser_clock_out is a register, loaded each edge with (phase_next <= hp_s). It is high for phases 0..hp_s and low for the rest; duty cycle is exactly 50%. It runs continuously, including in IDLE.
- Tick: asserted on the edge where phase_next == dly_s, once per slow period. ser_data_out changes only on tick edges.
- Holding buffer: one word. word_ready = ~buf_full. A transfer occurs on an edge with word_valid & word_ready, and sets buf_full.
- State machine:
  - IDLE:
    - ser_data_out held 0.
    - On a tick with buf_full: load buffer into the shift register, output MSB, bit_cnt=1, clear buf_full, go to SHIFT.
  - SHIFT, on each tick:
    - If bit_cnt<DATA_WIDTH: output next bit, bit_cnt++.
    - Else if buf_full: load the next word and output its MSB. Gapless back-to-back; stay in SHIFT.
    - Else: ser_data_out<=0, go to IDLE. If word_valid=1 on this edge, set underrun.
- Simultaneous events: a transfer on the same edge as a tick that empties the buffer is allowed. Buffer fill and drain resolve to buf_full=1 with the new word.
- Latency: a word accepted in IDLE appears at the first tick strictly after the accept edge, i.e. within P fast cycles.
- busy = (state==SHIFT) | buf_full.

Optional Feature:
- Macro SERIALISER_PARITY_EN.
- When defined: after the LSB, one extra tick outputs even parity (XOR of all DATA_WIDTH bits) before the next MSB or return to IDLE. A word is DATA_WIDTH+1 slow periods.
- When undefined: no parity bit; words are exactly DATA_WIDTH periods; no parity logic synthesised.

Decomposition:
- Package serialiser_pkg:
  - state enum {IDLE, SHIFT} (plus PARITY state under the macro).
  - Constants PARITY_BITS (0/1) and WORD_BITS = DATA_WIDTH+PARITY_BITS.
  - Bit-counter width function clog2(WORD_BITS+1).
- Sub-module serialiser_clockgen: phase counter, shadow registers, ser_clock_out and tick generation. The parent owns the buffer, shift register and FSM.

Test Plan (DATA_WIDTH=8):
- Clock generation: half_period=1, no words → ser_clock_out period 4 cycles, pattern 1,1,0,0 after the first shadow load; ser_data_out stays 0, busy=0.
- Single word: word_in=8'hA5 accepted in IDLE, half_period=1, delay=2 → ser_data_out = 1,0,1,0,0,1,0,1. Each bit changes 2 cycles after a ser_clock_out rise and lasts 4 cycles, then returns to 0; busy falls with the last bit.
- Back-to-back: 8'hFF then 8'h00 with word_valid held → 16 contiguous bits with no idle gap; word_ready low while the buffer is full; underrun=0.
- Clamp: delay=15, half_period=0 → dly_s=1; data changes on the falling-edge-aligned cycle; no missed ticks.
- Mid-period reconfiguration: half_period changed 1→3 mid-word → new 8-cycle period starts only at the next wrap; the in-flight bit is not truncated.
- Reset mid-word: reset=0 during bit 3 of 8'hC3 → outputs 0 immediately, buffer emptied. After release, ser_clock_out restarts from phase 0 and word_ready=1 one edge later.
- Parity (SERIALISER_PARITY_EN): word 8'h07 → 9th bit=1; word 8'h03 → 9th bit=0.

Source files
------------

// File: rtl/serialiser_pkg.sv
// serialiser_pkg: shared state encoding, parity constants and counter sizing.
// Optional feature macro: SERIALISER_PARITY_EN.  Rev 1.0
`default_nettype none

package serialiser_pkg;

`ifdef SERIALISER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
    localparam int PARITY_BITS = 1;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    localparam int PARITY_BITS = 0;
`endif

    function automatic int word_bits(input int data_width);
        return data_width + PARITY_BITS;
    endfunction

    function automatic int cnt_width(input int wbits);
        return $clog2(wbits + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serialiser_clockgen.sv
// serialiser_clockgen: phase counter, period-boundary shadow controls, slow clock and launch tick.
// Rev 1.0
`default_nettype none

module serialiser_clockgen
    import serialiser_pkg::*;
#(
    parameter int HP_WIDTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [HP_WIDTH-1:0] half_period,
    input  logic [HP_WIDTH-1:0] delay,
    output logic                ser_clock_out,
    output logic                tick
);

    localparam int PW = HP_WIDTH + 1;

    logic [PW-1:0]       phase;
    logic [PW-1:0]       phase_next;
    logic [PW-1:0]       last_phase;
    logic [PW-1:0]       new_last;
    logic [HP_WIDTH-1:0] hp_s;
    logic [HP_WIDTH-1:0] dly_s;
    logic [HP_WIDTH-1:0] dly_new;

    assign last_phase = {hp_s, 1'b1};
    assign phase_next = (phase == last_phase) ? '0 : phase + PW'(1);

    // A launch delay beyond the period would never tick; clamp to the last phase.
    assign new_last = {half_period, 1'b1};
    assign dly_new  = ({1'b0, delay} > new_last) ? new_last[HP_WIDTH-1:0] : delay;

    assign tick = (phase_next == {1'b0, dly_s});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase         <= '0;
            hp_s          <= '1;
            dly_s         <= '0;
            ser_clock_out <= 1'b0;
        end else begin
            phase         <= phase_next;
            ser_clock_out <= (phase_next <= {1'b0, hp_s});
            if (phase_next == '0) begin
                hp_s  <= half_period;
                dly_s <= dly_new;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/serialiser.sv
// serialiser: one-word buffered parallel-to-serial transmitter with generated slow clock.
// Optional even parity bit per word under SERIALISER_PARITY_EN.  Rev 1.0
`default_nettype none

module serialiser
    import serialiser_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int HP_WIDTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [HP_WIDTH-1:0]   half_period,
    input  logic [HP_WIDTH-1:0]   delay,
    input  logic [DATA_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  ser_clock_out,
    output logic                  ser_data_out,
    output logic                  busy,
    output logic                  underrun
);

    localparam int               CW       = cnt_width(word_bits(DATA_WIDTH));
    localparam logic [CW-1:0]    LAST_BIT = CW'(DATA_WIDTH);

    logic                  tick;
    state_t                state;
    logic [DATA_WIDTH-1:0] hold_word;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  buf_full;
    logic [CW-1:0]         bit_cnt;
    logic                  accept;
    logic                  word_end;
    logic                  drain;
    logic                  buf_full_next;
`ifdef SERIALISER_PARITY_EN
    logic                  parity;
`endif

    serialiser_clockgen #(
        .HP_WIDTH      (HP_WIDTH)
    ) u_clockgen (
        .clock         (clock),
        .reset         (reset),
        .half_period   (half_period),
        .delay         (delay),
        .ser_clock_out (ser_clock_out),
        .tick          (tick)
    );

    assign accept = word_valid & word_ready;
`ifdef SERIALISER_PARITY_EN
    assign word_end = (state == PARITY);
`else
    assign word_end = (state == SHIFT) && (bit_cnt == LAST_BIT);
`endif
    assign drain         = tick & buf_full & ((state == IDLE) | word_end);
    assign buf_full_next = accept | (buf_full & ~drain);
    assign busy          = (state != IDLE) | buf_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            hold_word    <= '0;
            shreg        <= '0;
            buf_full     <= 1'b0;
            bit_cnt      <= '0;
            word_ready   <= 1'b0;
            ser_data_out <= 1'b0;
            underrun     <= 1'b0;
`ifdef SERIALISER_PARITY_EN
            parity       <= 1'b0;
`endif
        end else begin
            if (accept) begin
                hold_word <= word_in;
            end
            buf_full   <= buf_full_next;
            word_ready <= ~buf_full_next;

            if (tick) begin
                if (drain) begin
                    // Load straight from the buffer so consecutive words have no gap.
                    shreg        <= hold_word << 1;
                    ser_data_out <= hold_word[DATA_WIDTH-1];
                    bit_cnt      <= CW'(1);
                    state        <= SHIFT;
`ifdef SERIALISER_PARITY_EN
                    parity       <= ^hold_word;
`endif
                end else if (word_end) begin
                    ser_data_out <= 1'b0;
                    state        <= IDLE;
                    if (word_valid) begin
                        underrun <= 1'b1;
                    end
                end else if (state == SHIFT) begin
`ifdef SERIALISER_PARITY_EN
                    if (bit_cnt == LAST_BIT) begin
                        ser_data_out <= parity;
                        state        <= PARITY;
                    end else
`endif
                    begin
                        ser_data_out <= shreg[DATA_WIDTH-1];
                        shreg        <= shreg << 1;
                        bit_cnt      <= bit_cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
